// File: rtl/pc_unit.sv
// Program-counter unit: increment, stall, branch, call/return via a
// circular return-address stack, and trap redirect with EPC capture.
// Ports: clk, reset (sync, high); controls enable, take_branch,
//   is_relative_branch, is_call, is_return, trap; branch_addr operand;
//   outputs pc_out, epc_out, ras_count, ras_underflow (all registered).
module pc_unit #(
  parameter int unsigned          ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = 'h10,
  parameter int unsigned          RAS_DEPTH   = 4,
  localparam int unsigned         CW = $clog2(RAS_DEPTH + 1),
  localparam int unsigned         PW = $clog2(RAS_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  take_branch,
  input  logic                  is_relative_branch,
  input  logic                  is_call,
  input  logic                  is_return,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  input  logic                  trap,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] epc_out,
  output logic [CW-1:0]         ras_count,
  output logic                  ras_underflow
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_epc;
  logic [ADDR_WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]         r_ptr;
  logic [CW-1:0]         r_cnt;
  logic                  r_uf;

  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [ADDR_WIDTH-1:0] w_target;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [ADDR_WIDTH-1:0] w_epc_nxt;
  logic [PW-1:0]         w_ptr_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  w_uf_nxt;
  logic                  w_push;

  assign w_pc_inc = r_pc + ADDR_WIDTH'(1);
  assign w_target = is_relative_branch ? r_pc + branch_addr
                                       : branch_addr;

  always_comb begin
    w_pc_nxt  = r_pc;
    w_epc_nxt = r_epc;
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    w_uf_nxt  = r_uf;
    w_push    = 1'b0;
    if (trap) begin
      w_pc_nxt  = TRAP_VECTOR;
      w_epc_nxt = r_pc;
    end else if (!enable) begin
      w_pc_nxt = r_pc;
    end else if (is_return) begin
      if (r_cnt != '0) begin
        w_pc_nxt  = r_ras[r_ptr];
        w_ptr_nxt = r_ptr - PW'(1);
        w_cnt_nxt = r_cnt - CW'(1);
      end else begin
        w_pc_nxt = w_pc_inc;
        w_uf_nxt = 1'b1;
      end
    end else if (take_branch) begin
      w_pc_nxt = w_target;
      if (is_call) begin
        // When full the write lands on the oldest slot, so the
        // newest RAS_DEPTH return addresses survive.
        w_push    = 1'b1;
        w_ptr_nxt = r_ptr + PW'(1);
        if (r_cnt != CW'(RAS_DEPTH))
          w_cnt_nxt = r_cnt + CW'(1);
      end
    end else begin
      w_pc_nxt = w_pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= RESET_ADDR;
      r_epc <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
      r_uf  <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_epc <= w_epc_nxt;
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
      r_uf  <= w_uf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push)
      r_ras[w_ptr_nxt] <= w_pc_inc;
  end

  assign pc_out        = r_pc;
  assign epc_out       = r_epc;
  assign ras_count     = r_cnt;
  assign ras_underflow = r_uf;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: scenario tasks push expected
// state to a scoreboard queue and compare one cycle later.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        take_branch;
  logic        is_relative_branch;
  logic        is_call;
  logic        is_return;
  logic [31:0] branch_addr;
  logic        trap;
  logic [31:0] pc_out;
  logic [31:0] epc_out;
  logic [2:0]  ras_count;
  logic        ras_underflow;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic rst, en, tb, rel, call, ret, trp;
    logic [31:0] a;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [2:0]  cnt;
    logic        uf;
  } exp_t;

  exp_t sb[$];

  pc_unit dut (
    .clk(clk), .reset(reset), .enable(enable),
    .take_branch(take_branch),
    .is_relative_branch(is_relative_branch),
    .is_call(is_call), .is_return(is_return),
    .branch_addr(branch_addr), .trap(trap),
    .pc_out(pc_out), .epc_out(epc_out),
    .ras_count(ras_count), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  function automatic stim_t S(logic rst, logic en, logic tb_,
                              logic rel, logic call, logic ret,
                              logic trp, logic [31:0] a);
    stim_t s;
    s.rst = rst; s.en = en; s.tb = tb_; s.rel = rel;
    s.call = call; s.ret = ret; s.trp = trp; s.a = a;
    return s;
  endfunction

  function automatic exp_t E(logic [31:0] pc, logic [31:0] epc,
                             logic [2:0] cnt, logic uf);
    exp_t e;
    e.pc = pc; e.epc = epc; e.cnt = cnt; e.uf = uf;
    return e;
  endfunction

  // rst en tb rel call ret trap addr
  function automatic stim_t RST();       return S(1,0,0,0,0,0,0,0); endfunction
  function automatic stim_t INC();       return S(0,1,0,0,0,0,0,0); endfunction
  function automatic stim_t STL();       return S(0,0,0,0,0,0,0,0); endfunction
  function automatic stim_t ABS(logic [31:0] a); return S(0,1,1,0,0,0,0,a); endfunction
  function automatic stim_t REL(logic [31:0] a); return S(0,1,1,1,0,0,0,a); endfunction
  function automatic stim_t CAL(logic [31:0] a); return S(0,1,1,0,1,0,0,a); endfunction
  function automatic stim_t CLR(logic [31:0] a); return S(0,1,1,1,1,0,0,a); endfunction
  function automatic stim_t RET();       return S(0,1,0,0,0,1,0,0); endfunction

  task automatic apply(input stim_t s);
    @(negedge clk);
    reset = s.rst; enable = s.en; take_branch = s.tb;
    is_relative_branch = s.rel; is_call = s.call;
    is_return = s.ret; trap = s.trp; branch_addr = s.a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    sb.push_back(E(32'h0, 32'h0, 3'd0, 1'b0));
    apply(RST());
    e = sb.pop_front();
    n_checks++;
    if (pc_out !== e.pc) begin n_fails++;
      $display("FAIL reset pc got %h want %h", pc_out, e.pc); end
    n_checks++;
    if (epc_out !== e.epc) begin n_fails++;
      $display("FAIL reset epc got %h want %h", epc_out, e.epc); end
    n_checks++;
    if (ras_count !== e.cnt) begin n_fails++;
      $display("FAIL reset cnt got %0d want %0d", ras_count, e.cnt); end
    n_checks++;
    if (ras_underflow !== e.uf) begin n_fails++;
      $display("FAIL reset uf got %b want %b", ras_underflow, e.uf); end
  endtask

  task automatic test_increment();
    stim_t st[$];
    exp_t  e;
    st = '{INC(), INC(), INC(), STL(), STL(), REL(32'hFFFF_FFFE)};
    sb.push_back(E(1, 0, 0, 0)); sb.push_back(E(2, 0, 0, 0));
    sb.push_back(E(3, 0, 0, 0)); sb.push_back(E(3, 0, 0, 0));
    sb.push_back(E(3, 0, 0, 0)); sb.push_back(E(1, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (pc_out !== e.pc) begin n_fails++;
        $display("FAIL inc[%0d] pc got %h want %h", i, pc_out, e.pc); end
      n_checks++;
      if (ras_count !== e.cnt) begin n_fails++;
        $display("FAIL inc[%0d] cnt got %0d want %0d", i, ras_count, e.cnt); end
    end
  endtask

  task automatic test_branch_wrap();
    stim_t st[$];
    exp_t  e;
    st = '{ABS(32'hFFFF_FFFF), INC(), ABS(32'h40), REL(32'h10)};
    sb.push_back(E(32'hFFFF_FFFF, 0, 0, 0));
    sb.push_back(E(32'h0, 0, 0, 0));
    sb.push_back(E(32'h40, 0, 0, 0));
    sb.push_back(E(32'h50, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (pc_out !== e.pc) begin n_fails++;
        $display("FAIL branch[%0d] pc got %h want %h", i, pc_out, e.pc); end
    end
  endtask

  task automatic test_call_return();
    stim_t st[$];
    exp_t  e;
    st = '{ABS(5), CAL(32'h100), CLR(32'h20),
           S(0,0,0,0,0,1,0,0), RET(), RET(), RET(), INC()};
    sb.push_back(E(5, 0, 0, 0));
    sb.push_back(E(32'h100, 0, 1, 0));
    sb.push_back(E(32'h120, 0, 2, 0));
    sb.push_back(E(32'h120, 0, 2, 0));
    sb.push_back(E(32'h101, 0, 1, 0));
    sb.push_back(E(6, 0, 0, 0));
    sb.push_back(E(7, 0, 0, 1));
    sb.push_back(E(8, 0, 0, 1));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (pc_out !== e.pc) begin n_fails++;
        $display("FAIL callret[%0d] pc got %h want %h", i, pc_out, e.pc); end
      n_checks++;
      if (ras_count !== e.cnt) begin n_fails++;
        $display("FAIL callret[%0d] cnt got %0d want %0d", i, ras_count, e.cnt); end
      n_checks++;
      if (ras_underflow !== e.uf) begin n_fails++;
        $display("FAIL callret[%0d] uf got %b want %b", i, ras_underflow, e.uf); end
    end
  endtask

  task automatic test_ras_overflow();
    stim_t st[$];
    exp_t  e;
    st = '{RST(), ABS(10), CAL(20), CAL(30), CAL(40), CAL(50), CAL(60),
           RET(), RET(), RET(), RET(), RET()};
    sb.push_back(E(0, 0, 0, 0));
    sb.push_back(E(10, 0, 0, 0));
    sb.push_back(E(20, 0, 1, 0));
    sb.push_back(E(30, 0, 2, 0));
    sb.push_back(E(40, 0, 3, 0));
    sb.push_back(E(50, 0, 4, 0));
    sb.push_back(E(60, 0, 4, 0));
    sb.push_back(E(51, 0, 3, 0));
    sb.push_back(E(41, 0, 2, 0));
    sb.push_back(E(31, 0, 1, 0));
    sb.push_back(E(21, 0, 0, 0));
    sb.push_back(E(22, 0, 0, 1));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (pc_out !== e.pc) begin n_fails++;
        $display("FAIL ovf[%0d] pc got %0d want %0d", i, pc_out, e.pc); end
      n_checks++;
      if (ras_count !== e.cnt) begin n_fails++;
        $display("FAIL ovf[%0d] cnt got %0d want %0d", i, ras_count, e.cnt); end
      n_checks++;
      if (ras_underflow !== e.uf) begin n_fails++;
        $display("FAIL ovf[%0d] uf got %b want %b", i, ras_underflow, e.uf); end
    end
  endtask

  task automatic test_trap();
    stim_t st[$];
    exp_t  e;
    // trap while stalled, with take_branch also high
    st = '{RST(), ABS(32'h32), CAL(32'h33), S(0,0,1,0,0,0,1,32'h77),
           RET(), INC()};
    sb.push_back(E(0, 0, 0, 0));
    sb.push_back(E(32'h32, 0, 0, 0));
    sb.push_back(E(32'h33, 0, 1, 0));
    sb.push_back(E(32'h10, 32'h33, 1, 0));
    sb.push_back(E(32'h33, 32'h33, 0, 0));
    sb.push_back(E(32'h34, 32'h33, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (pc_out !== e.pc) begin n_fails++;
        $display("FAIL trap[%0d] pc got %h want %h", i, pc_out, e.pc); end
      n_checks++;
      if (epc_out !== e.epc) begin n_fails++;
        $display("FAIL trap[%0d] epc got %h want %h", i, epc_out, e.epc); end
      n_checks++;
      if (ras_count !== e.cnt) begin n_fails++;
        $display("FAIL trap[%0d] cnt got %0d want %0d", i, ras_count, e.cnt); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    exp_t  e;
    // return beats call+branch; then reset drops pending entries
    st = '{ABS(32'h7F), CAL(32'h200), S(0,1,1,0,1,1,0,32'h300),
           RET(), CAL(32'h90), CAL(32'hA0), RST(), INC()};
    sb.push_back(E(32'h7F, 32'h33, 0, 0));
    sb.push_back(E(32'h200, 32'h33, 1, 0));
    sb.push_back(E(32'h80, 32'h33, 0, 0));
    sb.push_back(E(32'h81, 32'h33, 0, 1));
    sb.push_back(E(32'h90, 32'h33, 1, 1));
    sb.push_back(E(32'hA0, 32'h33, 2, 1));
    sb.push_back(E(32'h0, 32'h0, 0, 0));
    sb.push_back(E(32'h1, 32'h0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb.pop_front();
      n_checks++;
      if (pc_out !== e.pc) begin n_fails++;
        $display("FAIL b2b[%0d] pc got %h want %h", i, pc_out, e.pc); end
      n_checks++;
      if (epc_out !== e.epc) begin n_fails++;
        $display("FAIL b2b[%0d] epc got %h want %h", i, epc_out, e.epc); end
      n_checks++;
      if (ras_count !== e.cnt) begin n_fails++;
        $display("FAIL b2b[%0d] cnt got %0d want %0d", i, ras_count, e.cnt); end
      n_checks++;
      if (ras_underflow !== e.uf) begin n_fails++;
        $display("FAIL b2b[%0d] uf got %b want %b", i, ras_underflow, e.uf); end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; take_branch = 1'b0;
    is_relative_branch = 1'b0; is_call = 1'b0; is_return = 1'b0;
    trap = 1'b0; branch_addr = '0;
    test_reset();
    test_increment();
    test_branch_wrap();
    // back to pc=0 region: branch state carried, so reset first
    test_reset();
    test_call_return();
    test_ras_overflow();
    test_trap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit, the next generation of the core's PC controller. Generalised address width and reset address. Adds call/return support through an internal return-address stack (RAS) and a trap redirect that captures the faulting PC in an EPC register. Sits at the head of the fetch path and drives the instruction-memory address every cycle.

Parameters:
ADDR_WIDTH, 32, width of PC, branch operand, EPC and RAS entries
RESET_ADDR, 0, PC value after reset
TRAP_VECTOR, 'h10, PC loaded on trap
RAS_DEPTH, 4, number of return-stack entries (power of two, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  advance PC this cycle; 0 = stall (trap still honoured)
take_branch  input  1  redirect PC using branch_addr
is_relative_branch  input  1  1 = pc + branch_addr, 0 = absolute branch_addr
is_call  input  1  qualifies take_branch: also push return address
is_return  input  1  redirect PC to RAS top and pop
branch_addr  input  ADDR_WIDTH  absolute target or two's-complement offset
trap  input  1  redirect to TRAP_VECTOR, capture EPC
pc_out  output  ADDR_WIDTH  current PC (registered)
epc_out  output  ADDR_WIDTH  PC at most recent trap
ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries
ras_underflow  output  1  sticky: return issued with empty RAS

Behaviour:
- Reset (synchronous, highest priority): pc=RESET_ADDR, epc=0, ras_count=0, ras_underflow=0, RAS pointer=0. RAS entry contents are don't-care.
- All outputs are direct register outputs. A redirect requested in cycle N is visible on pc_out in cycle N+1.
- Priority when not in reset: trap > stall (!enable) > return > branch/call > increment.
- trap: pc<=TRAP_VECTOR, epc<=current pc. Applies even when enable=0. RAS untouched. Other controls ignored.
- stall (enable=0, no trap): pc, RAS and flags all hold.
- return (is_return=1):
  - ras_count>0: pc<=RAS top, pop, ras_count-1.
  - ras_count==0: pc<=pc+1, ras_underflow<=1 (sticky until reset).
  - take_branch and is_call are ignored in a return cycle.
- branch (take_branch=1): target = is_relative_branch ? pc+branch_addr : branch_addr; pc<=target.
- call (take_branch=1 and is_call=1): branch as above, and push pc+1.
  - RAS not full: ras_count+1.
  - RAS full: overwrite the oldest entry (circular). ras_count stays RAS_DEPTH, so the newest RAS_DEPTH returns are preserved.
- is_call without take_branch: ignored. Plain increment.
- increment: pc<=pc+1.
- Arithmetic: all adds are modulo 2^ADDR_WIDTH. PC wraps from all-ones to 0. A relative offset is two's complement, e.g. 'hFFFFFFFF = -1.
- RAS implemented as a circular buffer: a top pointer plus a count. Push writes at ptr+1; pop reads at ptr and decrements. Pointer arithmetic is modulo RAS_DEPTH.
- Reset asserted mid-sequence (e.g. with calls outstanding) empties the RAS immediately. The next cycle's pc_out = RESET_ADDR.

Test Plan:
- Reset then enable=1 for 3 cycles -> pc_out 0,1,2,3. Hold enable=0 for 2 cycles -> pc_out stays 3. Relative branch with branch_addr='hFFFFFFFE at pc=3 -> pc_out=1.
- Absolute branch to 'hFFFFFFFF, then increment -> pc_out wraps to 0. Absolute branch to 'h40 -> pc_out='h40.
- At pc=5 call absolute 'h100 -> pc='h100, ras_count=1. At 'h100 call relative +'h20 -> pc='h120, ras_count=2. Return -> pc='h101. Return -> pc=6, ras_count=0. Return again -> pc=7, ras_underflow=1 and it stays 1.
- RAS_DEPTH=4: five nested calls from pcs 10,20,30,40,50 -> ras_count=4. Four returns yield 51,41,31,21, then ras_count=0 with no underflow. A fifth return sets ras_underflow.
- At pc='h33 with enable=0, assert trap with take_branch=1 -> pc='h10, epc_out='h33, RAS unchanged.
- Same-cycle is_return + take_branch + is_call with ras_count=1 (top='h80) -> pc='h80, ras_count=0, no push. Then reset with 2 entries pending -> pc=RESET_ADDR, ras_count=0, ras_underflow=0.
